pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline-register and hazard-response block for the 5-stage RV32I core.
- Produces the IF/ID, ID/EX, EX/MEM and MEM/WB instruction words that the forwarding/stall unit inspects.
- Consumes that unit's stall request and the EX-stage branch/jump redirect.
- Holds PC and IF/ID, injects NOP bubbles, flushes wrong-path instructions, and keeps hazard statistics.

Parameters:
- NOP, 32'h00000013, bubble word (addi x0,x0,0), the reset value of every stage register.
- CNT_W, 16, width of the saturating statistics counters.
- MAX_STALL, 1, maximum legal consecutive stall cycles before the error flag sets.

Ports:
- CLK  in  1  core clock, rising edge.
- RSTn  in  1  asynchronous active-low reset.
- i_inst  in  32  fetched instruction for the current PC.
- i_inst_valid  in  1  i_inst is valid this cycle (instruction-memory handshake).
- i_pc  in  32  PC of i_inst.
- i_stall  in  1  load-use stall request from the forwarding/stall unit.
- i_flush  in  1  taken branch/JAL/JALR resolved in EX; kill IF/ID and ID/EX.
- o_pc_we  out  1  PC register write enable.
- o_fetch_ready  out  1  IF/ID can accept i_inst this cycle.
- IF_ID  out  32  instruction word in the ID stage.
- ID_EX  out  32  instruction word in the EX stage.
- EX_MEM  out  32  instruction word in the MEM stage.
- MEM_WB  out  32  instruction word in the WB stage.
- o_if_id_pc  out  32  PC paired with IF_ID.
- o_id_ex_pc  out  32  PC paired with ID_EX.
- o_stall_cnt  out  CNT_W  saturating count of stall cycles.
- o_flush_cnt  out  CNT_W  saturating count of flush events.
- o_retire_cnt  out  CNT_W  saturating count of non-NOP words leaving WB.
- o_stall_err  out  1  sticky: stall held longer than MAX_STALL cycles.

Behaviour:
- Reset (RSTn low, asynchronous): all four stage words = NOP; PCs = 0; counters = 0; o_stall_err = 0; internal stall-run counter = 0.
- Combinational controls:
  - o_pc_we = i_inst_valid & (~i_stall | i_flush).
  - o_fetch_ready = ~i_stall | i_flush.
- Per-cycle priority: flush > stall > fetch-empty > normal.
- Flush (i_flush = 1):
  - IF_ID <= NOP, ID_EX <= NOP, EX_MEM <= ID_EX, MEM_WB <= EX_MEM.
  - o_flush_cnt increments.
  - Any simultaneous stall is ignored and does not count.
- Stall (i_stall = 1, no flush):
  - IF_ID and o_if_id_pc hold; ID_EX <= NOP; EX_MEM and MEM_WB advance normally.
  - o_stall_cnt increments.
- Fetch empty (i_inst_valid = 0, no stall, no flush): IF_ID <= NOP; later stages advance.
- Normal:
  - IF_ID <= i_inst, o_if_id_pc <= i_pc.
  - ID_EX <= IF_ID, o_id_ex_pc <= o_if_id_pc.
  - EX_MEM <= ID_EX, MEM_WB <= EX_MEM.
- Latency: an accepted instruction reaches IF_ID 1 cycle later and MEM_WB 4 cycles later, plus 1 cycle per stall.
- Stall-run counter:
  - Increments on each stall cycle; clears on any non-stall cycle.
  - o_stall_err sets when the counter would exceed MAX_STALL. It stays set until reset.
  - The stall is still honoured when the error sets.
- Retire: o_retire_cnt increments each cycle in which MEM_WB != NOP, evaluated on the value leaving WB.
- Counters: saturate at all-ones, with no wrap.
- Reset mid-stall or mid-flush: all state returns to reset values immediately. The pipeline restarts from NOPs.

Decomposition:
- Shared package (rv_pipe_pkg): NOP constant, RV32I opcode localparams (LOAD, OP, OP_IMM, JALR, JAL, BRANCH, STORE), CNT_W default.
- The forwarding/stall unit uses the same opcode list.
- One natural sub-module: sat_counter (parameterised width, inc, synchronous saturate). Instantiate it three times.

Test Plan:
- Reset, then stream 0x00500093, 0x00A00113 with valid=1 -> IF_ID=0x00500093 after 1 cycle, MEM_WB=0x00500093 after 4 cycles; o_retire_cnt=1 in the following cycle.
- Load 0x0000A083 followed by 0x00108133, i_stall=1 for 1 cycle -> IF_ID holds 0x00108133, ID_EX=0x00000013, o_pc_we=0, o_stall_cnt=1.
- i_flush=1 while IF_ID=0x00208193 and ID_EX=0x0000006F -> next cycle IF_ID=ID_EX=NOP, EX_MEM=0x0000006F, o_flush_cnt=1.
- i_stall=1 and i_flush=1 together -> flush behaviour only; o_stall_cnt unchanged; o_pc_we=i_inst_valid.
- i_stall held 2 cycles with MAX_STALL=1 -> o_stall_err=1 after the 2nd cycle and stays 1; force counters to 0xFFFF -> they hold 0xFFFF.
- RSTn pulsed low mid-stall -> all stage words read 0x00000013 immediately; counters and o_stall_err read 0.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared constants and cycle classification for the RV32I pipeline
package rv_pipe_pkg;

  localparam logic [31:0] NOP_WORD      = 32'h00000013;
  localparam int          CNT_W_DEF     = 16;
  localparam int          MAX_STALL_DEF = 1;

  // Major opcodes, shared with the forwarding/stall unit
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef enum logic [1:0] {
    CYC_NORMAL,
    CYC_EMPTY,
    CYC_STALL,
    CYC_FLUSH
  } cyc_kind_e;

  function automatic cyc_kind_e classify(input logic flush, input logic stall, input logic valid);
    if (flush)       return CYC_FLUSH;
    else if (stall)  return CYC_STALL;
    else if (!valid) return CYC_EMPTY;
    else             return CYC_NORMAL;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - fetch/hazard inputs and stage/statistics outputs of pipe_hazard_ctrl
interface pipe_hazard_ctrl_if import rv_pipe_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
);

  logic [31:0]      i_inst;
  logic             i_inst_valid;
  logic [31:0]      i_pc;
  logic             i_stall;
  logic             i_flush;
  logic             o_pc_we;
  logic             o_fetch_ready;
  logic [31:0]      IF_ID;
  logic [31:0]      ID_EX;
  logic [31:0]      EX_MEM;
  logic [31:0]      MEM_WB;
  logic [31:0]      o_if_id_pc;
  logic [31:0]      o_id_ex_pc;
  logic [CNT_W-1:0] o_stall_cnt;
  logic [CNT_W-1:0] o_flush_cnt;
  logic [CNT_W-1:0] o_retire_cnt;
  logic             o_stall_err;

  modport master (
    output i_inst, i_inst_valid, i_pc, i_stall, i_flush,
    input  o_pc_we, o_fetch_ready, IF_ID, ID_EX, EX_MEM, MEM_WB,
    input  o_if_id_pc, o_id_ex_pc, o_stall_cnt, o_flush_cnt, o_retire_cnt, o_stall_err
  );

  modport slave (
    input  i_inst, i_inst_valid, i_pc, i_stall, i_flush,
    output o_pc_we, o_fetch_ready, IF_ID, ID_EX, EX_MEM, MEM_WB,
    output o_if_id_pc, o_id_ex_pc, o_stall_cnt, o_flush_cnt, o_retire_cnt, o_stall_err
  );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stage registers with stall/flush/bubble handling
// and saturating hazard statistics for the 5-stage RV32I core.
module pipe_hazard_ctrl import rv_pipe_pkg::*; #(
  parameter logic [31:0] NOP       = NOP_WORD,
  parameter int          CNT_W     = CNT_W_DEF,
  parameter int          MAX_STALL = MAX_STALL_DEF
) (
  input logic              CLK,
  input logic              RSTn,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int RUN_W = 8;

  cyc_kind_e        kind;
  logic [31:0]      if_id_q,    if_id_d;
  logic [31:0]      id_ex_q,    id_ex_d;
  logic [31:0]      ex_mem_q,   ex_mem_d;
  logic [31:0]      mem_wb_q,   mem_wb_d;
  logic [31:0]      if_id_pc_q, if_id_pc_d;
  logic [31:0]      id_ex_pc_q, id_ex_pc_d;
  logic [RUN_W-1:0] run_q,      run_d;
  logic             err_q,      err_d;

  // A flush outranks a simultaneous stall: the stalled instruction is on the wrong path anyway
  assign kind              = classify(bus.i_flush, bus.i_stall, bus.i_inst_valid);
  assign bus.o_pc_we       = bus.i_inst_valid & (~bus.i_stall | bus.i_flush);
  assign bus.o_fetch_ready = ~bus.i_stall | bus.i_flush;

  always_comb begin
    if_id_d    = if_id_q;
    id_ex_d    = id_ex_q;
    if_id_pc_d = if_id_pc_q;
    id_ex_pc_d = id_ex_pc_q;
    ex_mem_d   = id_ex_q;
    mem_wb_d   = ex_mem_q;
    case (kind)
      CYC_FLUSH: begin
        if_id_d = NOP;
        id_ex_d = NOP;
      end
      CYC_STALL: begin
        id_ex_d = NOP;
      end
      CYC_EMPTY: begin
        if_id_d    = NOP;
        id_ex_d    = if_id_q;
        id_ex_pc_d = if_id_pc_q;
      end
      default: begin
        if_id_d    = bus.i_inst;
        if_id_pc_d = bus.i_pc;
        id_ex_d    = if_id_q;
        id_ex_pc_d = if_id_pc_q;
      end
    endcase
  end

  // Length of the current run of honoured stalls; flagged once it would pass MAX_STALL
  always_comb begin
    run_d = '0;
    err_d = err_q;
    if (kind == CYC_STALL) begin
      run_d = (run_q == {RUN_W{1'b1}}) ? run_q : run_q + {{(RUN_W-1){1'b0}}, 1'b1};
      if ((int'(run_q) + 1) > MAX_STALL) err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      if_id_q    <= NOP;
      id_ex_q    <= NOP;
      ex_mem_q   <= NOP;
      mem_wb_q   <= NOP;
      if_id_pc_q <= '0;
      id_ex_pc_q <= '0;
      run_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      if_id_q    <= if_id_d;
      id_ex_q    <= id_ex_d;
      ex_mem_q   <= ex_mem_d;
      mem_wb_q   <= mem_wb_d;
      if_id_pc_q <= if_id_pc_d;
      id_ex_pc_q <= id_ex_pc_d;
      run_q      <= run_d;
      err_q      <= err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .rst_n (RSTn),
    .inc   (kind == CYC_STALL),
    .cnt   (bus.o_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (CLK),
    .rst_n (RSTn),
    .inc   (kind == CYC_FLUSH),
    .cnt   (bus.o_flush_cnt)
  );

  // Retirement is judged on the word leaving WB, i.e. the current MEM/WB contents
  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk   (CLK),
    .rst_n (RSTn),
    .inc   (mem_wb_q != NOP),
    .cnt   (bus.o_retire_cnt)
  );

  assign bus.IF_ID       = if_id_q;
  assign bus.ID_EX       = id_ex_q;
  assign bus.EX_MEM      = ex_mem_q;
  assign bus.MEM_WB      = mem_wb_q;
  assign bus.o_if_id_pc  = if_id_pc_q;
  assign bus.o_id_ex_pc  = id_ex_pc_q;
  assign bus.o_stall_err = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scenario bench for pipe_hazard_ctrl with a retire-order scoreboard
module tb_pipe_hazard_ctrl;
  import rv_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W_DEF)) bus ();
  pipe_hazard_ctrl_if #(.CNT_W(4)) bus_s ();

  assign bus_s.i_inst       = bus.i_inst;
  assign bus_s.i_inst_valid = bus.i_inst_valid;
  assign bus_s.i_pc         = bus.i_pc;
  assign bus_s.i_stall      = bus.i_stall;
  assign bus_s.i_flush      = bus.i_flush;

  pipe_hazard_ctrl #(.CNT_W(CNT_W_DEF)) dut (.CLK(clk), .RSTn(rst_n), .bus(bus));
  pipe_hazard_ctrl #(.CNT_W(4))         dut_s (.CLK(clk), .RSTn(rst_n), .bus(bus_s));

  task automatic drive(input logic [31:0] inst, input logic v, input logic [31:0] pc,
                       input logic st, input logic fl);
    bus.i_inst = inst; bus.i_inst_valid = v; bus.i_pc = pc; bus.i_stall = st; bus.i_flush = fl;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    step(); step();
    checks++; if (bus.IF_ID !== NOP_WORD || bus.ID_EX !== NOP_WORD || bus.EX_MEM !== NOP_WORD || bus.MEM_WB !== NOP_WORD) begin
      errors++; $display("FAIL reset_stages got %h %h %h %h want all %h", bus.IF_ID, bus.ID_EX, bus.EX_MEM, bus.MEM_WB, NOP_WORD); end
    checks++; if (bus.o_stall_cnt !== 16'd0 || bus.o_flush_cnt !== 16'd0 || bus.o_retire_cnt !== 16'd0 || bus.o_stall_err !== 1'b0) begin
      errors++; $display("FAIL reset_counters got %0d %0d %0d err %b want 0 0 0 err 0", bus.o_stall_cnt, bus.o_flush_cnt, bus.o_retire_cnt, bus.o_stall_err); end
    checks++; if (bus.o_if_id_pc !== 32'h0 || bus.o_id_ex_pc !== 32'h0) begin
      errors++; $display("FAIL reset_pcs got %h %h want 0 0", bus.o_if_id_pc, bus.o_id_ex_pc); end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    drive(32'h00500093, 1'b1, 32'h0, 1'b0, 1'b0);
    sb_q.push_back(32'h00500093);
    step();
    checks++; if (bus.IF_ID !== 32'h00500093 || bus.o_if_id_pc !== 32'h0) begin
      errors++; $display("FAIL stream_if_id got %h pc %h want 00500093 pc 0", bus.IF_ID, bus.o_if_id_pc); end
    drive(32'h00A00113, 1'b1, 32'h4, 1'b0, 1'b0);
    sb_q.push_back(32'h00A00113);
    step();
    checks++; if (bus.ID_EX !== 32'h00500093 || bus.IF_ID !== 32'h00A00113 || bus.o_id_ex_pc !== 32'h0) begin
      errors++; $display("FAIL stream_id_ex got %h/%h pc %h want 00500093/00a00113 pc 0", bus.ID_EX, bus.IF_ID, bus.o_id_ex_pc); end
    drive(32'h0, 1'b0, 32'h8, 1'b0, 1'b0);
    step(); step();
    exp = sb_q.pop_front();
    checks++; if (bus.MEM_WB !== exp || bus.o_retire_cnt !== 16'd0) begin
      errors++; $display("FAIL stream_mem_wb got %h retire %0d want %h retire 0", bus.MEM_WB, bus.o_retire_cnt, exp); end
    step();
    exp = sb_q.pop_front();
    checks++; if (bus.o_retire_cnt !== 16'd1 || bus.MEM_WB !== exp) begin
      errors++; $display("FAIL stream_retire1 got %0d/%h want 1/%h", bus.o_retire_cnt, bus.MEM_WB, exp); end
    step();
    checks++; if (bus.o_retire_cnt !== 16'd2) begin
      errors++; $display("FAIL stream_retire2 got %0d want 2", bus.o_retire_cnt); end
    step(); step(); step();
  endtask

  task automatic test_stall();
    drive(32'h0000A083, 1'b1, 32'h10, 1'b0, 1'b0); step();
    drive(32'h00108133, 1'b1, 32'h14, 1'b0, 1'b0); step();
    drive(32'h00208193, 1'b1, 32'h18, 1'b1, 1'b0); #1;
    checks++; if (bus.o_pc_we !== 1'b0 || bus.o_fetch_ready !== 1'b0) begin
      errors++; $display("FAIL stall_ctrl got pc_we %b ready %b want 0 0", bus.o_pc_we, bus.o_fetch_ready); end
    step();
    checks++; if (bus.IF_ID !== 32'h00108133 || bus.o_if_id_pc !== 32'h14 || bus.ID_EX !== NOP_WORD || bus.EX_MEM !== 32'h0000A083) begin
      errors++; $display("FAIL stall_stages got %h pc %h %h %h want 00108133 pc 14 00000013 0000a083", bus.IF_ID, bus.o_if_id_pc, bus.ID_EX, bus.EX_MEM); end
    checks++; if (bus.o_stall_cnt !== 16'd1) begin
      errors++; $display("FAIL stall_cnt got %0d want 1", bus.o_stall_cnt); end
    drive(32'h00208193, 1'b1, 32'h18, 1'b0, 1'b0); step();
    checks++; if (bus.IF_ID !== 32'h00208193 || bus.ID_EX !== 32'h00108133 || bus.o_id_ex_pc !== 32'h14) begin
      errors++; $display("FAIL stall_release got %h %h pc %h want 00208193 00108133 pc 14", bus.IF_ID, bus.ID_EX, bus.o_id_ex_pc); end
  endtask

  task automatic test_flush();
    drive(32'h0000006F, 1'b1, 32'h20, 1'b0, 1'b0); step();
    drive(32'h00208193, 1'b1, 32'h24, 1'b0, 1'b0); step();
    drive(32'h00000513, 1'b1, 32'h40, 1'b0, 1'b1); #1;
    checks++; if (bus.o_pc_we !== 1'b1 || bus.o_fetch_ready !== 1'b1) begin
      errors++; $display("FAIL flush_ctrl got pc_we %b ready %b want 1 1", bus.o_pc_we, bus.o_fetch_ready); end
    step();
    checks++; if (bus.IF_ID !== NOP_WORD || bus.ID_EX !== NOP_WORD || bus.EX_MEM !== 32'h0000006F || bus.o_flush_cnt !== 16'd1) begin
      errors++; $display("FAIL flush_stages got %h %h %h cnt %0d want 00000013 00000013 0000006f cnt 1", bus.IF_ID, bus.ID_EX, bus.EX_MEM, bus.o_flush_cnt); end
  endtask

  task automatic test_stall_flush();
    drive(32'h00300213, 1'b1, 32'h50, 1'b0, 1'b0); step();
    drive(32'h00400293, 1'b1, 32'h54, 1'b0, 1'b0); step();
    drive(32'h00500313, 1'b0, 32'h58, 1'b1, 1'b1); #1;
    checks++; if (bus.o_pc_we !== 1'b0 || bus.o_fetch_ready !== 1'b1) begin
      errors++; $display("FAIL sf_ctrl_invalid got pc_we %b ready %b want 0 1", bus.o_pc_we, bus.o_fetch_ready); end
    bus.i_inst_valid = 1'b1; #1;
    checks++; if (bus.o_pc_we !== 1'b1) begin
      errors++; $display("FAIL sf_ctrl_valid got pc_we %b want 1", bus.o_pc_we); end
    step();
    checks++; if (bus.IF_ID !== NOP_WORD || bus.ID_EX !== NOP_WORD || bus.EX_MEM !== 32'h00300213) begin
      errors++; $display("FAIL sf_stages got %h %h %h want 00000013 00000013 00300213", bus.IF_ID, bus.ID_EX, bus.EX_MEM); end
    checks++; if (bus.o_stall_cnt !== 16'd1 || bus.o_flush_cnt !== 16'd2) begin
      errors++; $display("FAIL sf_counts got stall %0d flush %0d want 1 2", bus.o_stall_cnt, bus.o_flush_cnt); end
  endtask

  task automatic test_stall_err();
    checks++; if (bus.o_stall_err !== 1'b0) begin
      errors++; $display("FAIL err_before got %b want 0", bus.o_stall_err); end
    drive(32'h00500093, 1'b1, 32'h60, 1'b1, 1'b0); step();
    checks++; if (bus.o_stall_err !== 1'b0 || bus.o_stall_cnt !== 16'd2) begin
      errors++; $display("FAIL err_first got %b cnt %0d want 0 cnt 2", bus.o_stall_err, bus.o_stall_cnt); end
    step();
    checks++; if (bus.o_stall_err !== 1'b1 || bus.o_stall_cnt !== 16'd3 || bus.ID_EX !== NOP_WORD) begin
      errors++; $display("FAIL err_second got %b cnt %0d id_ex %h want 1 cnt 3 id_ex 00000013", bus.o_stall_err, bus.o_stall_cnt, bus.ID_EX); end
    drive(32'h0, 1'b0, 32'h64, 1'b0, 1'b0); step(); step();
    checks++; if (bus.o_stall_err !== 1'b1) begin
      errors++; $display("FAIL err_sticky got %b want 1", bus.o_stall_err); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [6];
    logic [31:0] exp;
    int idx;
    int cyc;
    logic st;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) words[i] = 32'h00000093 + (32'(i + 1) << 20);
    idx = 0;
    cyc = 0;
    while (idx < 6 && cyc < 20) begin
      st = (cyc == 2);
      drive(words[idx], 1'b1, 32'(idx * 4), st, 1'b0);
      if (!st) sb_q.push_back(words[idx]);
      step();
      if (bus.MEM_WB !== NOP_WORD) begin
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : NOP_WORD;
        checks++; if (bus.MEM_WB !== exp) begin
          errors++; $display("FAIL b2b_order got %h want %h", bus.MEM_WB, exp); end
      end
      if (!st) idx++;
      cyc++;
    end
    drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step();
      if (bus.MEM_WB !== NOP_WORD) begin
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : NOP_WORD;
        checks++; if (bus.MEM_WB !== exp) begin
          errors++; $display("FAIL b2b_order got %h want %h", bus.MEM_WB, exp); end
      end
    end
    checks++; if (sb_q.size() != 0) begin
      errors++; $display("FAIL b2b_drain got %0d pending want 0", sb_q.size()); sb_q.delete(); end
    checks++; if (bus.o_retire_cnt !== 16'd6 || bus.o_stall_cnt !== 16'd1 || bus.o_flush_cnt !== 16'd0 || bus.o_stall_err !== 1'b0) begin
      errors++; $display("FAIL b2b_counts got %0d %0d %0d err %b want 6 1 0 err 0", bus.o_retire_cnt, bus.o_stall_cnt, bus.o_flush_cnt, bus.o_stall_err); end
  endtask

  task automatic test_saturate();
    for (int i = 1; i <= 16; i++) begin
      drive(32'h00000093 + (32'(i) << 20), 1'b1, 32'(i * 4), 1'b0, 1'b0); step();
    end
    drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) step();
    checks++; if (bus.o_retire_cnt !== 16'd22 || bus_s.o_retire_cnt !== 4'hF) begin
      errors++; $display("FAIL sat_retire got %0d/%h want 22/f", bus.o_retire_cnt, bus_s.o_retire_cnt); end
    drive(32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) step();
    checks++; if (bus.o_stall_cnt !== 16'd21 || bus_s.o_stall_cnt !== 4'hF || bus.o_stall_err !== 1'b1) begin
      errors++; $display("FAIL sat_stall got %0d/%h err %b want 21/f err 1", bus.o_stall_cnt, bus_s.o_stall_cnt, bus.o_stall_err); end
    for (int k = 0; k < 3; k++) step();
    checks++; if (bus_s.o_stall_cnt !== 4'hF || bus.o_stall_cnt !== 16'd24) begin
      errors++; $display("FAIL sat_stall_hold got %h/%0d want f/24", bus_s.o_stall_cnt, bus.o_stall_cnt); end
    drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 18; k++) step();
    checks++; if (bus.o_flush_cnt !== 16'd18 || bus_s.o_flush_cnt !== 4'hF) begin
      errors++; $display("FAIL sat_flush got %0d/%h want 18/f", bus.o_flush_cnt, bus_s.o_flush_cnt); end
    drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0); step();
  endtask

  task automatic test_reset_mid_stall();
    drive(32'h00100093, 1'b1, 32'h80, 1'b0, 1'b0); step();
    drive(32'h00200113, 1'b1, 32'h84, 1'b0, 1'b0); step();
    drive(32'h00300193, 1'b1, 32'h88, 1'b1, 1'b0); step();
    #2; rst_n = 1'b0; #1;
    checks++; if (bus.IF_ID !== NOP_WORD || bus.ID_EX !== NOP_WORD || bus.EX_MEM !== NOP_WORD || bus.MEM_WB !== NOP_WORD) begin
      errors++; $display("FAIL rst_mid_stages got %h %h %h %h want all 00000013", bus.IF_ID, bus.ID_EX, bus.EX_MEM, bus.MEM_WB); end
    checks++; if (bus.o_stall_cnt !== 16'd0 || bus.o_flush_cnt !== 16'd0 || bus.o_retire_cnt !== 16'd0 || bus.o_stall_err !== 1'b0 || bus_s.o_stall_cnt !== 4'h0) begin
      errors++; $display("FAIL rst_mid_counters got %0d %0d %0d err %b small %h want 0 0 0 err 0 small 0", bus.o_stall_cnt, bus.o_flush_cnt, bus.o_retire_cnt, bus.o_stall_err, bus_s.o_stall_cnt); end
    step();
    rst_n = 1'b1;
    drive(32'h00700393, 1'b1, 32'h100, 1'b0, 1'b0); step();
    checks++; if (bus.IF_ID !== 32'h00700393 || bus.o_if_id_pc !== 32'h100 || bus.ID_EX !== NOP_WORD) begin
      errors++; $display("FAIL rst_restart got %h pc %h id_ex %h want 00700393 pc 100 id_ex 00000013", bus.IF_ID, bus.o_if_id_pc, bus.ID_EX); end
  endtask

  initial begin
    drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_stall_flush();
    test_stall_err();
    test_back_to_back();
    test_saturate();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
